// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multi-cycle MIPS datapath. Sequences
//               fetch/decode/execute/memory/writeback and drives all datapath
//               enables, mux selects and the 2-bit ALUOp.
//               Optional macro MC_MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall
//               on mem_ready=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    RWB    = STATE_W'(7),
    BRANCH = STATE_W'(8),
    JUMP   = STATE_W'(9),
    ADDIEX = STATE_W'(10),
    ADDIWB = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctl_t;

  // Moore control word for a given state; everything not listed is 0.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
                    c.alu_src_b = 2'b01; end
      DECODE: begin c.alu_src_b = 2'b11; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                    c.pc_source = 2'b01; c.instr_done = 1'b1; end
      JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctl_t   ctl_q;
  logic   mem_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  // Without the wait feature memory always accepts in one cycle.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // Next-state selection and the DECODE-time illegal opcode pulse.
  always_comb begin
    state_d    = FETCH;
    illegal_op = 1'b0;
    case (state_q)
      FETCH:  state_d = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          OP_ADDI:       state_d = ADDIEX;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      // The IR still holds the opcode, so lw/sw is resolved here.
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ok ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = mem_ok ? FETCH : MEMWR;
      EXEC:   state_d = RWB;
      RWB:    state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // State register plus registered Moore decode of the upcoming state, so the
  // control word always matches state_q; reset lands in FETCH with no writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctl_q   <= decode_ctl(FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d);
    end
  end

  // Handshake gating: IR/PC load in FETCH and completion in MEMWR wait for
  // the accepting cycle. mem_ok is constant 1 when the feature is off.
  assign ir_write      = ctl_q.ir_write & mem_ok;
  assign pc_write      = ctl_q.pc_write & (mem_ok | (state_q != FETCH));
  assign instr_done    = ctl_q.instr_done & (mem_ok | (state_q != MEMWR));
  assign pc_write_cond = ctl_q.pc_write_cond;
  assign i_or_d        = ctl_q.i_or_d;
  assign mem_read      = ctl_q.mem_read;
  assign mem_write     = ctl_q.mem_write;
  assign mem_to_reg    = ctl_q.mem_to_reg;
  assign reg_dst       = ctl_q.reg_dst;
  assign reg_write     = ctl_q.reg_write;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign alu_op        = ctl_q.alu_op;
  assign pc_source     = ctl_q.pc_source;
  assign pc_en         = pc_write | (pc_write_cond & zero);
  assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state);
    end
    checks++;
    if ({pc_write, mem_read, ir_write, reg_write, mem_write} !== 5'b11100) begin
      errors++; $display("FAIL reset_fetch_ctl: got %b want 11100",
                         {pc_write, mem_read, ir_write, reg_write, mem_write});
    end
    checks++;
    if (alu_src_b !== 2'b01 || alu_op !== 2'b00) begin
      errors++; $display("FAIL reset_fetch_alu: got b=%b op=%b want b=01 op=00", alu_src_b, alu_op);
    end
  endtask

  task automatic test_rtype();
    int seq [5] = '{0, 1, 6, 7, 0};
    int done_cnt = 0;
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      if (i < 4) done_cnt += int'(instr_done);
      if (seq[i] == 6) begin
        checks++;
        if (alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
          errors++; $display("FAIL rtype_exec: got op=%b a=%b b=%b want op=10 a=1 b=00",
                             alu_op, alu_src_a, alu_src_b);
        end
      end
      if (seq[i] == 7) begin
        checks++;
        if ({reg_write, reg_dst, instr_done} !== 3'b111) begin
          errors++; $display("FAIL rtype_rwb: got %b want 111", {reg_write, reg_dst, instr_done});
        end
      end
      if (i < 4) step();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL rtype_done_pulses: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_lw();
    int seq [6] = '{0, 1, 2, 3, 4, 0};
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      if (seq[i] == 2) begin
        checks++;
        if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin
          errors++; $display("FAIL lw_memadr: got a=%b b=%b op=%b want a=1 b=10 op=00",
                             alu_src_a, alu_src_b, alu_op);
        end
      end
      if (seq[i] == 3) begin
        checks++;
        if ({i_or_d, mem_read, mem_write} !== 3'b110) begin
          errors++; $display("FAIL lw_memrd: got %b want 110", {i_or_d, mem_read, mem_write});
        end
      end
      if (seq[i] == 4) begin
        checks++;
        if ({mem_to_reg, reg_write, reg_dst, instr_done} !== 4'b1101) begin
          errors++; $display("FAIL lw_memwb: got %b want 1101",
                             {mem_to_reg, reg_write, reg_dst, instr_done});
        end
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_sw();
    int seq [5] = '{0, 1, 2, 5, 0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      if (seq[i] == 5) begin
        checks++;
        if ({mem_write, i_or_d, instr_done, mem_read, reg_write} !== 5'b11100) begin
          errors++; $display("FAIL sw_memwr: got %b want 11100",
                             {mem_write, i_or_d, instr_done, mem_read, reg_write});
        end
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_branch(input logic z);
    int seq [4] = '{0, 1, 8, 0};
    opcode = 6'b000100;
    zero   = z;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL beq_state[%0d] z=%b: got %0d want %0d", i, z, state, seq[i]);
      end
      if (seq[i] == 1) begin
        checks++;
        if (alu_src_b !== 2'b11 || alu_op !== 2'b00) begin
          errors++; $display("FAIL decode_alu: got b=%b op=%b want b=11 op=00", alu_src_b, alu_op);
        end
      end
      if (seq[i] == 8) begin
        checks++;
        if (alu_op !== 2'b01 || pc_source !== 2'b01 || pc_write_cond !== 1'b1 || instr_done !== 1'b1) begin
          errors++; $display("FAIL beq_ctl: got op=%b src=%b cond=%b done=%b want 01 01 1 1",
                             alu_op, pc_source, pc_write_cond, instr_done);
        end
        checks++;
        if (pc_en !== z) begin
          errors++; $display("FAIL beq_pc_en z=%b: got %b want %b", z, pc_en, z);
        end
      end
      if (i < 3) step();
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    int seq [4] = '{0, 1, 9, 0};
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      if (seq[i] == 9) begin
        checks++;
        if ({pc_write, pc_en, instr_done, pc_source} !== 5'b11110) begin
          errors++; $display("FAIL j_ctl: got %b want 11110", {pc_write, pc_en, instr_done, pc_source});
        end
      end
      if (i < 3) step();
    end
  endtask

  task automatic test_addi();
    int seq [5] = '{0, 1, 10, 11, 0};
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== 4'(seq[i])) begin
        errors++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, seq[i]);
      end
      if (seq[i] == 10) begin
        checks++;
        if (alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b00) begin
          errors++; $display("FAIL addi_ex: got a=%b b=%b op=%b want 1 10 00",
                             alu_src_a, alu_src_b, alu_op);
        end
      end
      if (seq[i] == 11) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg, instr_done} !== 4'b1001) begin
          errors++; $display("FAIL addi_wb: got %b want 1001",
                             {reg_write, reg_dst, mem_to_reg, instr_done});
        end
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_in_fetch: got %b want 0", illegal_op);
    end
    step();
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b1) begin
      errors++; $display("FAIL illegal_decode: got state=%0d ill=%b want 1 1", state, illegal_op);
    end
    checks++;
    if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL illegal_no_write: got rw=%b mw=%b want 0 0", reg_write, mem_write);
    end
    step();
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_next: got state=%0d ill=%b want 0 0", state, illegal_op);
    end
  endtask

  task automatic test_reset_mid_memrd();
    opcode = 6'b100011;
    step(); step(); step();
    checks++;
    if (state !== 4'd3) begin
      errors++; $display("FAIL abort_reach_memrd: got %0d want 3", state);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL abort_async_state: got %0d want 0", state);
    end
    checks++;
    if (i_or_d !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL abort_no_pending: got iord=%b rw=%b mw=%b want 0 0 0",
                         i_or_d, reg_write, mem_write);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({state, pc_write, mem_read, ir_write} !== 7'b0000111) begin
      errors++; $display("FAIL abort_release: got state=%0d pw=%b mr=%b irw=%b want 0 1 1 1",
                         state, pc_write, mem_read, ir_write);
    end
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({state, ir_write, pc_write, mem_read} !== 7'b0000001) begin
        errors++; $display("FAIL wait_fetch_stall[%0d]: got state=%0d irw=%b pw=%b mr=%b want 0 0 0 1",
                           i, state, ir_write, pc_write, mem_read);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_write, pc_write} !== 6'b000011) begin
      errors++; $display("FAIL wait_fetch_accept: got state=%0d irw=%b pw=%b want 0 1 1",
                         state, ir_write, pc_write);
    end
    step();
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL wait_to_decode: got %0d want 1", state);
    end
    step(); step(); step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL wait_back_fetch: got %0d want 0", state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_addi();
    test_illegal();
    test_reset_mid_memrd();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
